// File: rtl/cpu_types_pkg.sv
// Shared CPU types for the execute stage: multiply/divide op codes, the
// multiply/divide unit state encoding and its iteration count.
package cpu_types_pkg;

  typedef enum logic [1:0] {
    MD_MULT  = 2'd0,
    MD_MULTU = 2'd1,
    MD_DIV   = 2'd2,
    MD_DIVU  = 2'd3
  } mdu_op_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    FIX  = 2'd2
  } mdu_state_t;

  localparam int MDU_ITER = 32;

  // Divide ops take the shift-subtract path; everything else shift-adds.
  function automatic logic is_div_op(input mdu_op_t op);
    return (op == MD_DIV) || (op == MD_DIVU);
  endfunction

  // Signed ops work on magnitudes and fix the signs up at the end.
  function automatic logic is_signed_op(input mdu_op_t op);
    return (op == MD_MULT) || (op == MD_DIV);
  endfunction

endpackage

// File: rtl/mdu_if.sv
// Handshake bundle between control and the multiply/divide unit.
interface mdu_if
  import cpu_types_pkg::*;
#(
  parameter int WORD_W = 32
);
  logic              start;
  mdu_op_t           mdOp;
  logic [WORD_W-1:0] portA;
  logic [WORD_W-1:0] portB;
  logic              busy;
  logic              done;
  logic [WORD_W-1:0] hi;
  logic [WORD_W-1:0] lo;
  logic              divZero;

  modport mdu (
    input  start, mdOp, portA, portB,
    output busy, done, hi, lo, divZero
  );

  modport cu (
    output start, mdOp, portA, portB,
    input  busy, done, hi, lo, divZero
  );
endinterface

// File: rtl/mult_div_unit.sv
// Multi-cycle MULT/MULTU/DIV/DIVU unit. Works on operand magnitudes one bit
// per cycle, then applies the sign correction and writes HI/LO in one step.
module mult_div_unit
  import cpu_types_pkg::*;
#(
  parameter int WORD_W = 32,
  parameter int ITER   = WORD_W
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              start,
  input  mdu_op_t           mdOp,
  input  logic [WORD_W-1:0] portA,
  input  logic [WORD_W-1:0] portB,
  output logic              busy,
  output logic              done,
  output logic [WORD_W-1:0] hi,
  output logic [WORD_W-1:0] lo,
  output logic              divZero
);

  localparam int CNT_W = $clog2(ITER) + 1;
  localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(ITER - 1);

  mdu_state_t state, next_state;

  mdu_op_t             op_q;
  logic [WORD_W-1:0]   opa_q;
  logic [WORD_W-1:0]   opb_q;
  logic [WORD_W-1:0]   dividend_q;
  logic                neg_q;
  logic                neg_r;
  logic                zero_div_q;
  logic [CNT_W-1:0]    cnt;
  logic [2*WORD_W-1:0] acc;
  logic [WORD_W-1:0]   rem;
  logic [WORD_W-1:0]   quo;

  logic [WORD_W-1:0]   mag_a;
  logic [WORD_W-1:0]   mag_b;
  logic                start_signed;
  logic [WORD_W:0]     mul_sum;
  logic [WORD_W:0]     div_shift;
  logic [WORD_W:0]     div_diff;
  logic                div_ge;

  function automatic logic [WORD_W-1:0] abs_w(input logic [WORD_W-1:0] v);
    return v[WORD_W-1] ? -v : v;
  endfunction

  // State register; reset drops any operation in flight.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) state <= IDLE;
    else     state <= next_state;
  end

  // Next-state: accept in IDLE, iterate ITER times, one fix-up cycle.
  always_comb begin
    next_state = state;
    unique case (state)
      IDLE:    if (start) next_state = CALC;
      CALC:    if (cnt == LAST_ITER) next_state = FIX;
      FIX:     next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  // Operand conditioning and the single-bit multiply/divide step.
  always_comb begin
    start_signed = is_signed_op(mdOp);
    mag_a        = start_signed ? abs_w(portA) : portA;
    mag_b        = start_signed ? abs_w(portB) : portB;
    mul_sum      = {1'b0, acc[2*WORD_W-1:WORD_W]};
    if (acc[0]) mul_sum = {1'b0, acc[2*WORD_W-1:WORD_W]} + {1'b0, opa_q};
    div_shift    = {rem, quo[WORD_W-1]};
    div_diff     = div_shift - {1'b0, opb_q};
    div_ge       = !div_diff[WORD_W];
  end

  // Datapath: latch at acceptance, iterate in CALC, publish results in FIX.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      op_q       <= MD_MULT;
      opa_q      <= '0;
      opb_q      <= '0;
      dividend_q <= '0;
      neg_q      <= 1'b0;
      neg_r      <= 1'b0;
      zero_div_q <= 1'b0;
      cnt        <= '0;
      acc        <= '0;
      rem        <= '0;
      quo        <= '0;
      busy       <= 1'b0;
      done       <= 1'b0;
      hi         <= '0;
      lo         <= '0;
      divZero    <= 1'b0;
    end else begin
      done <= 1'b0;
      unique case (state)
        IDLE: begin
          if (start) begin
            op_q       <= mdOp;
            opa_q      <= mag_a;
            opb_q      <= mag_b;
            dividend_q <= portA;
            neg_q      <= start_signed & (portA[WORD_W-1] ^ portB[WORD_W-1]);
            neg_r      <= start_signed & portA[WORD_W-1];
            zero_div_q <= is_div_op(mdOp) && (portB == '0);
            cnt        <= '0;
            acc        <= {{WORD_W{1'b0}}, mag_b};
            rem        <= '0;
            quo        <= mag_a;
            busy       <= 1'b1;
          end
        end
        CALC: begin
          cnt <= cnt + 1'b1;
          if (is_div_op(op_q)) begin
            rem <= div_ge ? div_diff[WORD_W-1:0] : div_shift[WORD_W-1:0];
            quo <= {quo[WORD_W-2:0], div_ge};
          end else begin
            acc <= {mul_sum, acc[WORD_W-1:1]};
          end
        end
        FIX: begin
          busy    <= 1'b0;
          done    <= 1'b1;
          divZero <= zero_div_q;
          if (is_div_op(op_q)) begin
            if (zero_div_q) begin
              hi <= dividend_q;
              lo <= '1;
            end else begin
              hi <= neg_r ? -rem : rem;
              lo <= neg_q ? -quo : quo;
            end
          end else begin
            {hi, lo} <= neg_q ? -acc : acc;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mult_div_unit.sv
// Directed bench for mult_div_unit: latency, busy window, results, divide by
// zero, ignored restarts, asynchronous reset abort and signed overflow.
module tb_mult_div_unit;
  import cpu_types_pkg::*;

  logic        CLK;
  logic        RST;
  logic        start;
  mdu_op_t     mdOp;
  logic [31:0] portA;
  logic [31:0] portB;
  logic        busy;
  logic        done;
  logic [31:0] hi;
  logic [31:0] lo;
  logic        divZero;

  int checks;
  int errors;

  logic [31:0] prevHi;
  logic [31:0] prevLo;
  logic        prevDz;

  mult_div_unit #(.WORD_W(32), .ITER(32)) dut (
    .CLK     (CLK),
    .RST     (RST),
    .start   (start),
    .mdOp    (mdOp),
    .portA   (portA),
    .portB   (portB),
    .busy    (busy),
    .done    (done),
    .hi      (hi),
    .lo      (lo),
    .divZero (divZero)
  );

  // 10 ns clock
  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  task automatic checkOutput(input string tag, input logic [63:0] actual,
                             input logic [63:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %h expected %h", tag, actual, expected);
    end
  endtask

  // Launch one op (optionally chained at the current done negedge), watch the
  // busy window for a bounded number of cycles, then check the result.
  task automatic applyStimulus(input string tag, input mdu_op_t op,
                               input logic [31:0] a, input logic [31:0] b,
                               input logic [31:0] expHi, input logic [31:0] expLo,
                               input logic expDz, input int injectCycle,
                               input bit chained, input bit checkPulse);
    int  cyc;
    int  busyCycles;
    bit  seen;
    if (!chained) @(negedge CLK);
    mdOp  = op;
    portA = a;
    portB = b;
    start = 1'b1;
    @(posedge CLK);
    #1;
    start = 1'b0;
    portA = $urandom;
    portB = $urandom;
    mdOp  = MD_DIVU;
    cyc = 1;
    busyCycles = 0;
    seen = 0;
    while (cyc <= 40) begin
      @(negedge CLK);
      if (done) begin
        seen = 1;
        break;
      end
      if (busy) busyCycles++;
      if (cyc == 20) begin
        checkOutput({tag, "_hold_hi"}, {32'h0, hi}, {32'h0, prevHi});
        checkOutput({tag, "_hold_lo"}, {32'h0, lo}, {32'h0, prevLo});
        checkOutput({tag, "_hold_dz"}, {63'h0, divZero}, {63'h0, prevDz});
      end
      if (cyc == injectCycle) begin
        start = 1'b1;
        mdOp  = MD_MULT;
        portA = 32'hFFFFFFFF;
        portB = 32'd5;
      end
      @(posedge CLK);
      #1;
      start = 1'b0;
      cyc++;
    end
    checkOutput({tag, "_seen_done"}, {63'h0, seen}, 64'h1);
    checkOutput({tag, "_latency"}, 64'(cyc), 64'd34);
    checkOutput({tag, "_busy_cycles"}, 64'(busyCycles), 64'd33);
    checkOutput({tag, "_busy_at_done"}, {63'h0, busy}, 64'h0);
    checkOutput({tag, "_hi"}, {32'h0, hi}, {32'h0, expHi});
    checkOutput({tag, "_lo"}, {32'h0, lo}, {32'h0, expLo});
    checkOutput({tag, "_dz"}, {63'h0, divZero}, {63'h0, expDz});
    prevHi = expHi;
    prevLo = expLo;
    prevDz = expDz;
    if (checkPulse) begin
      @(negedge CLK);
      checkOutput({tag, "_done_pulse"}, {63'h0, done}, 64'h0);
      checkOutput({tag, "_idle_busy"}, {63'h0, busy}, 64'h0);
    end
  endtask

  initial begin
    int doneCount;
    checks = 0;
    errors = 0;
    start  = 1'b0;
    mdOp   = MD_MULT;
    portA  = '0;
    portB  = '0;
    prevHi = '0;
    prevLo = '0;
    prevDz = 1'b0;

    RST = 1'b1;
    #1;
    checkOutput("rst_busy", {63'h0, busy}, 64'h0);
    checkOutput("rst_done", {63'h0, done}, 64'h0);
    checkOutput("rst_hi", {32'h0, hi}, 64'h0);
    checkOutput("rst_lo", {32'h0, lo}, 64'h0);
    checkOutput("rst_dz", {63'h0, divZero}, 64'h0);
    @(negedge CLK);
    @(negedge CLK);
    RST = 1'b0;

    applyStimulus("multu_max", MD_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF,
                  32'hFFFFFFFE, 32'h00000001, 1'b0, 0, 0, 1);
    applyStimulus("mult_neg", MD_MULT, 32'hFFFFFFF9, 32'd6,
                  32'hFFFFFFFF, 32'hFFFFFFD6, 1'b0, 0, 0, 1);
    applyStimulus("div_neg", MD_DIV, 32'hFFFFFFEF, 32'd5,
                  32'hFFFFFFFE, 32'hFFFFFFFD, 1'b0, 0, 0, 0);
    applyStimulus("divu_chain", MD_DIVU, 32'd100, 32'd7,
                  32'd2, 32'd14, 1'b0, 0, 1, 1);
    applyStimulus("divu_zero", MD_DIVU, 32'h12345678, 32'h0,
                  32'h12345678, 32'hFFFFFFFF, 1'b1, 0, 0, 1);
    applyStimulus("multu_after_dz", MD_MULTU, 32'd3, 32'd4,
                  32'h0, 32'd12, 1'b0, 0, 0, 1);
    applyStimulus("div_signed_zero", MD_DIV, 32'hFFFFFFFF, 32'h0,
                  32'hFFFFFFFF, 32'hFFFFFFFF, 1'b1, 0, 0, 1);
    applyStimulus("ignore_restart", MD_MULTU, 32'd1000, 32'd1000,
                  32'h0, 32'h000F4240, 1'b0, 10, 0, 0);
    doneCount = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge CLK);
      if (done) doneCount++;
    end
    checkOutput("ignore_no_extra_done", 64'(doneCount), 64'd0);
    checkOutput("ignore_idle_busy", {63'h0, busy}, 64'h0);

    @(negedge CLK);
    mdOp  = MD_MULT;
    portA = 32'd123;
    portB = 32'd456;
    start = 1'b1;
    @(posedge CLK);
    #1;
    start = 1'b0;
    repeat (14) @(posedge CLK);
    #2;
    RST = 1'b1;
    #1;
    checkOutput("abort_busy", {63'h0, busy}, 64'h0);
    checkOutput("abort_done", {63'h0, done}, 64'h0);
    checkOutput("abort_hi", {32'h0, hi}, 64'h0);
    checkOutput("abort_lo", {32'h0, lo}, 64'h0);
    checkOutput("abort_dz", {63'h0, divZero}, 64'h0);
    @(negedge CLK);
    @(negedge CLK);
    RST = 1'b0;
    prevHi = '0;
    prevLo = '0;
    prevDz = 1'b0;
    doneCount = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge CLK);
      if (done) doneCount++;
    end
    checkOutput("abort_no_done", 64'(doneCount), 64'd0);

    applyStimulus("div_overflow", MD_DIV, 32'h80000000, 32'hFFFFFFFF,
                  32'h0, 32'h80000000, 1'b0, 0, 0, 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/mult_div_unit.md
Name: mult_div_unit

Overview:
- Multi-cycle MIPS multiply/divide unit that sits beside the combinational ALU in the execute stage.
- Handles MULT, MULTU, DIV and DIVU, which are too deep for single-cycle logic.
- Control issues an operation with a start/busy/done handshake.
- The unit iterates one bit per cycle and writes the HI/LO result registers, which are read by MFHI/MFLO.

Parameters:
WORD_W, 32, operand and result width; HI/LO are WORD_W each.
ITER, WORD_W, iteration count; the counter width is clog2(ITER)+1.

Ports:
CLK  input  1  system clock, rising edge.
RST  input  1  asynchronous, active-high reset.
start  input  1  request pulse; sampled only in IDLE.
mdOp  input  2  mdu_op_t: MD_MULT=0, MD_MULTU=1, MD_DIV=2, MD_DIVU=3.
portA  input  32  multiplicand or dividend (rs).
portB  input  32  multiplier or divisor (rt).
busy  output  1  high while an operation is in flight.
done  output  1  one-cycle pulse when hi/lo have been updated.
hi  output  32  MULT: upper product word; DIV: remainder.
lo  output  32  MULT: lower product word; DIV: quotient.
divZero  output  1  set with done when a DIV/DIVU had portB==0; held until the next done.

Behaviour:
- Reset (asynchronous, any state): state=IDLE; busy=0, done=0, hi=0, lo=0, divZero=0; counter and accumulators=0.
- FSM states: IDLE, CALC, FIX.
  - IDLE: on start=1 at edge E0:
    - latch mdOp;
    - latch |portA| and |portB| when the op is signed, otherwise the raw values;
    - record negQ = signA^signB and negR = signA (signed ops only);
    - counter=0; go to CALC; busy=1 from E0.
  - CALC: one iteration per edge.
    - MULT/MULTU: shift-add into a 64-bit accumulator.
    - DIV/DIVU: restoring shift-subtract into a 32-bit remainder and 32-bit quotient.
    - After ITER iterations (edges E1..E32) go to FIX.
  - FIX (edge E33):
    - Signed multiply: negate the 64-bit product if negQ.
    - Signed divide: negate the quotient if negQ and the remainder if negR.
    - Write hi/lo; done=1 for exactly one cycle; busy=0; go to IDLE.
- Latency: done is high in the cycle after E33 (34 edges after acceptance). A new start is accepted at that same edge E34, giving back-to-back throughput of 34 cycles.
- start while busy=1 is ignored: no queueing, no error. mdOp, portA and portB are don't-care after E0.
- Divide by zero (portB==0 on DIV/DIVU):
  - Latency is unchanged (34).
  - Result: hi=portA as presented (dividend), lo=32'hFFFFFFFF.
  - divZero=1 at done; cleared at the next done.
- Signed overflow 32'h80000000 / 32'hFFFFFFFF: lo=32'h80000000, hi=0, divZero=0 (the natural result of the magnitude algorithm).
- Multiply never overflows: the full 64-bit result is always produced.
- hi/lo/divZero change only at the FIX edge or on reset; they hold across IDLE.
- Reset mid-CALC aborts the operation: hi/lo return to 0 and no done is produced.

Decomposition:
- Add to cpu_types_pkg:
  - mdu_op_t enum (2 bits, values as listed under Ports);
  - mdu_state_t enum {IDLE, CALC, FIX};
  - localparam MDU_ITER=32.
- Add a new mdu_if interface with the modport mdu (unit side) and cu (control side).
- Sub-module: none required. Negation/absolute-value is a local function; a separate module is not warranted.

Test Plan:
- MD_MULTU, portA=32'hFFFFFFFF, portB=32'hFFFFFFFF -> done at cycle 34; hi=32'hFFFFFFFE, lo=32'h00000001; busy high for cycles 1..33.
- MD_MULT, portA=-7 (32'hFFFFFFF9), portB=6 -> hi=32'hFFFFFFFF, lo=32'hFFFFFFD6 (-42).
- MD_DIV, portA=-17, portB=5 -> lo=32'hFFFFFFFD (-3), hi=32'hFFFFFFFE (-2), divZero=0; then MD_DIVU with 100/7 issued at the done edge -> lo=14, hi=2, 34 cycles later.
- MD_DIVU, portA=32'h12345678, portB=0 -> lo=32'hFFFFFFFF, hi=32'h12345678, divZero=1. A following MD_MULTU 3*4 -> divZero=0, lo=12, hi=0.
- Second start pulsed at cycle 10 with different operands -> ignored; the original result is delivered at cycle 34 and busy drops once.
- RST asserted at cycle 15 of a MD_MULT -> outputs 0 immediately (asynchronous); no done. A new MD_DIV 0x80000000 / 0xFFFFFFFF after reset release -> lo=32'h80000000, hi=0.
